s510_cnt_gen: RTL and testbench

Counter and count-decode stage that sits directly upstream of the s510 next-state logic. It holds the controller's 10-bit event counter and a 3-bit `john` pulse prescaler. It produces the registered terminal-count strobes (`cnt10` … `cnt591`) and the `pcnt6` flag that the next-state cones consume alongside `st_0`…`st_5`. The `cnt_en`/`cnt_clr`/`pcnt_clr` controls come from the state register's output decode.

---
 rtl/s510_cnt_gen_if.sv | 23 ++
 rtl/s510_cnt_gen.sv | 69 ++++++
 tb/tb_s510_cnt_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/s510_cnt_gen_if.sv
// Control and decode bundle between the s510 state register and its counter stage.
interface s510_cnt_gen_if #(parameter int CW = 10);
   logic          cnt_en;
   logic          cnt_clr;
   logic          john;
   logic          pcnt_clr;
   logic [CW-1:0] cnt_q;
   logic          cnt10, cnt21, cnt44, cnt45, cnt261, cnt272;
   logic          cnt283, cnt284, cnt509, cnt511, cnt567, cnt591;
   logic          pcnt6;
   logic          john_q;

   modport master (
      output cnt_en, cnt_clr, john, pcnt_clr,
      input  cnt_q, cnt10, cnt21, cnt44, cnt45, cnt261, cnt272,
             cnt283, cnt284, cnt509, cnt511, cnt567, cnt591, pcnt6, john_q
   );
   modport slave (
      input  cnt_en, cnt_clr, john, pcnt_clr,
      output cnt_q, cnt10, cnt21, cnt44, cnt45, cnt261, cnt272,
             cnt283, cnt284, cnt509, cnt511, cnt567, cnt591, pcnt6, john_q
   );
endinterface

// File: rtl/s510_cnt_gen.sv
// s510 event counter, registered terminal-count decode and john-edge prescaler.
// Every output is a flop; strobes are loaded from the next count so they align with cnt_q.
module s510_cnt_gen #(
   parameter int CW = 10,
   parameter int PW = 3
) (
   input  logic           clock,
   input  logic           reset_n,
   s510_cnt_gen_if.slave  bus
);
   localparam int NDEC = 12;
   localparam int unsigned DVAL [NDEC] = '{10, 21, 44, 45, 261, 272, 283, 284, 509, 511, 567, 591};

   logic [CW-1:0]   cnt_r, cnt_nxt;
   logic [NDEC-1:0] dec_nxt, dec_r;
   logic [PW-1:0]   pcnt_r, pcnt_nxt;
   logic            john_r, pcnt6_r, john_rise;

   always_comb begin
      cnt_nxt = cnt_r;
      if (bus.cnt_clr)     cnt_nxt = '0;
      else if (bus.cnt_en) cnt_nxt = cnt_r + CW'(1);
   end

   for (genvar i = 0; i < NDEC; i++) begin : g_dec
      assign dec_nxt[i] = (cnt_nxt == CW'(DVAL[i]));
   end

   assign john_rise = bus.john & ~john_r;

   // Saturate rather than wrap so pcnt6 stays sticky until an explicit clear.
   always_comb begin
      pcnt_nxt = pcnt_r;
      if (bus.pcnt_clr)                      pcnt_nxt = '0;
      else if (john_rise && pcnt_r != '1)    pcnt_nxt = pcnt_r + PW'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r   <= '0;
         dec_r   <= '0;
         pcnt_r  <= '0;
         pcnt6_r <= 1'b0;
         john_r  <= 1'b0;
      end else begin
         cnt_r   <= cnt_nxt;
         dec_r   <= dec_nxt;
         pcnt_r  <= pcnt_nxt;
         pcnt6_r <= (32'(pcnt_nxt) >= 32'd6);
         john_r  <= bus.john;
      end
   end

   assign bus.cnt_q  = cnt_r;
   assign bus.cnt10  = dec_r[0];
   assign bus.cnt21  = dec_r[1];
   assign bus.cnt44  = dec_r[2];
   assign bus.cnt45  = dec_r[3];
   assign bus.cnt261 = dec_r[4];
   assign bus.cnt272 = dec_r[5];
   assign bus.cnt283 = dec_r[6];
   assign bus.cnt284 = dec_r[7];
   assign bus.cnt509 = dec_r[8];
   assign bus.cnt511 = dec_r[9];
   assign bus.cnt567 = dec_r[10];
   assign bus.cnt591 = dec_r[11];
   assign bus.pcnt6  = pcnt6_r;
   assign bus.john_q = john_r;
endmodule

// File: tb/tb_s510_cnt_gen.sv
// Bench for s510_cnt_gen: vector table, directed corner sequences and a randomized run
// checked every cycle against a counting model.
module tb_s510_cnt_gen;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   s510_cnt_gen_if #(.CW(10)) bus ();
   s510_cnt_gen #(.CW(10), .PW(3)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   int checks = 0, errors = 0;
   int m_cnt, m_pcnt, m_jq;
   int dval [12] = '{10, 21, 44, 45, 261, 272, 283, 284, 509, 511, 567, 591};
   int pulses [12];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] act_dec();
      return {bus.cnt591, bus.cnt567, bus.cnt511, bus.cnt509, bus.cnt284, bus.cnt283,
              bus.cnt272, bus.cnt261, bus.cnt45, bus.cnt44, bus.cnt21, bus.cnt10};
   endfunction

   function automatic logic [11:0] exp_dec();
      logic [11:0] d = '0;
      for (int i = 0; i < 12; i++) d[i] = (m_cnt == dval[i]);
      return d;
   endfunction

   task automatic cmp_model();
      chk("cnt_q", int'(bus.cnt_q), m_cnt);
      chk("strobes", int'(act_dec()), int'(exp_dec()));
      chk("pcnt6", int'(bus.pcnt6), int'(m_pcnt >= 6));
      chk("john_q", int'(bus.john_q), m_jq);
   endtask

   task automatic step(input logic en, input logic clr, input logic j, input logic pc);
      bus.cnt_en = en; bus.cnt_clr = clr; bus.john = j; bus.pcnt_clr = pc;
      @(posedge clock);
      if (clr)     m_cnt = 0;
      else if (en) m_cnt = (m_cnt + 1) % 1024;
      if (pc)                   m_pcnt = 0;
      else if (j && m_jq == 0)  m_pcnt = (m_pcnt < 7) ? m_pcnt + 1 : 7;
      m_jq = int'(j);
      #1;
      cmp_model();
      for (int i = 0; i < 12; i++) if (act_dec()[i]) pulses[i]++;
   endtask

   task automatic jpulse();
      step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
   endtask

   typedef struct {logic en, clr, j, pc; int ecnt; logic ep6;} vec_t;
   vec_t tbl [8];

   initial begin
      tbl[0] = '{1, 0, 0, 0, 1, 0};
      tbl[1] = '{1, 0, 1, 0, 2, 0};
      tbl[2] = '{0, 0, 1, 0, 2, 0};
      tbl[3] = '{1, 1, 0, 0, 0, 0};
      tbl[4] = '{1, 0, 0, 0, 1, 0};
      tbl[5] = '{0, 0, 0, 0, 1, 0};
      tbl[6] = '{1, 0, 1, 1, 2, 0};
      tbl[7] = '{0, 1, 0, 0, 0, 0};

      bus.cnt_en = 0; bus.cnt_clr = 0; bus.john = 0; bus.pcnt_clr = 0;
      m_cnt = 0; m_pcnt = 0; m_jq = 0;
      #12;
      chk("reset_cnt_q", int'(bus.cnt_q), 0);
      chk("reset_strobes", int'(act_dec()), 0);
      chk("reset_pcnt6", int'(bus.pcnt6), 0);
      reset_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 8; i++) begin
         step(tbl[i].en, tbl[i].clr, tbl[i].j, tbl[i].pc);
         chk($sformatf("tbl%0d_cnt", i), int'(bus.cnt_q), tbl[i].ecnt);
         chk($sformatf("tbl%0d_p6", i), int'(bus.pcnt6), int'(tbl[i].ep6));
      end

      // asynchronous reset mid-count, with pcnt6 also set
      step(0, 1, 0, 1);
      for (int i = 0; i < 6; i++) jpulse();
      for (int i = 0; i < 300; i++) step(1, 0, 0, 0);
      chk("pre_reset_cnt", int'(bus.cnt_q), 300);
      step(0, 0, 1, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("async_cnt_q", int'(bus.cnt_q), 0);
      chk("async_strobes", int'(act_dec()), 0);
      chk("async_pcnt6", int'(bus.pcnt6), 0);
      chk("async_john_q", int'(bus.john_q), 0);
      m_cnt = 0; m_pcnt = 0; m_jq = 0;
      bus.john = 0;
      #1 reset_n = 1'b1;
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
      chk("post_reset_cnt", int'(bus.cnt_q), 10);
      chk("post_reset_cnt10", int'(bus.cnt10), 1);

      // full sweep across the wrap
      step(0, 1, 0, 0);
      for (int i = 0; i < 12; i++) pulses[i] = 0;
      for (int i = 0; i < 1100; i++) begin
         step(1, 0, 0, 0);
         if (i == 1023) chk("wrap_to_0", int'(bus.cnt_q), 0);
      end
      for (int i = 0; i < 12; i++)
         chk($sformatf("sweep_pulses_%0d", dval[i]), pulses[i], (dval[i] < 77) ? 2 : 1);

      // hold at 44, then clear wins over enable
      step(0, 1, 0, 0);
      for (int i = 0; i < 44; i++) step(1, 0, 0, 0);
      chk("at44", int'(bus.cnt44), 1);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0);
         chk($sformatf("hold44_%0d", i), int'(bus.cnt44), 1);
      end
      step(1, 1, 0, 0);
      chk("clr_pri_cnt", int'(bus.cnt_q), 0);
      chk("clr_pri_cnt44", int'(bus.cnt44), 0);

      // prescaler pulses and saturation
      step(0, 0, 0, 1);
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 1, 0);
         chk($sformatf("p6_edge%0d", i), int'(bus.pcnt6), int'(i >= 6));
         step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      end

      // long high level is one edge
      step(0, 0, 0, 1);
      for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) jpulse();
      chk("level_once_p6_lo", int'(bus.pcnt6), 0);
      jpulse();
      chk("level_once_p6_hi", int'(bus.pcnt6), 1);

      // clear beats a simultaneous edge
      step(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) jpulse();
      step(0, 0, 1, 1);
      chk("clr_edge_p6", int'(bus.pcnt6), 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) jpulse();
      chk("after_clr_5edges", int'(bus.pcnt6), 0);
      jpulse();
      chk("after_clr_6edges", int'(bus.pcnt6), 1);

      // adjacent decodes 283/284/285
      step(0, 1, 0, 1);
      for (int i = 0; i < 283; i++) step(1, 0, 0, 0);
      chk("adj283", int'({bus.cnt283, bus.cnt284}), 2);
      step(0, 0, 0, 0); step(1, 0, 0, 0);
      chk("adj284", int'({bus.cnt283, bus.cnt284}), 1);
      step(0, 0, 0, 0); step(1, 0, 0, 0);
      chk("adj285", int'({bus.cnt283, bus.cnt284}), 0);

      // randomized run against the model
      for (int i = 0; i < 3000; i++)
         step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 49) == 0),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 31) == 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
